note_sequence_player: RTL and testbench
=======================================

# note_sequence_player

Transmit-side counterpart of the note-sequence word classifier. On a start request the block emits, one symbol at a time, the 4-bit note sequence that the classifier recognises as an adjective, comparative or adverb. Each symbol goes out over a valid/ready handshake whose transfers correspond one-to-one with the classifier's `ok` strobes. It sits between a word-type source (test controller or keypad logic) and the note bus that feeds the classifier.

## Interface
- `GAP`, default 2: idle cycles inserted after each accepted symbol before the next symbol is presented; legal range 0–15.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request to send one word; sampled only in IDLE.
- `tipo` input 2: word type. 01 = adjective, 10 = comparative, 11 = adverb, 00 = null (illegal).
- `var` input 1: branch select. 0 = la_m branch, 1 = si_m branch. Ignored for adverb.
- `raiz0` input 4: first stem note.
- `raiz1` input 4: second stem note.
- `nota` output 4: current note symbol.
- `nota_valid` output 1: `nota` is valid.
- `nota_ready` input 1: the sink accepts the symbol this cycle.
- `busy` output 1: a word is in progress.
- `done` output 1: one-cycle pulse after the final symbol is accepted.
- `erro` output 1: one-cycle pulse when a start request is rejected.

## Operation
- Note codes:
  - Pauses: 0000 and 1000. The block always emits 0000 as its pause.
  - do = 0001, re = 0010, la_m = 1110, si_m = 1111.
- Sequences, with symbol index 0..4:
  - Adjective, var = 0: raiz0, raiz1, la_m, pause (4 symbols).
  - Adjective, var = 1: raiz0, raiz1, si_m, pause (4 symbols).
  - Comparative, var = 0: raiz0, raiz1, la_m, do, pause (5 symbols).
  - Comparative, var = 1: raiz0, raiz1, si_m, re, pause (5 symbols).
  - Adverb: raiz0, raiz1, la_m, si_m, pause (5 symbols).
- Validation when `start` is sampled in IDLE:
  - The request is rejected if tipo = 00, or if raiz0 or raiz1 is 0000 or 1000.
  - On rejection: `erro` pulses for one cycle, nothing is emitted, and the block stays in IDLE.
- `tipo`, `var`, `raiz0` and `raiz1` are registered on an accepted start. Input changes after that point have no effect on the word in flight.
- State machine:
  - IDLE: on a valid start, go to SEND with index 0. On an invalid start, pulse `erro` and stay in IDLE.
  - SEND: `nota_valid` = 1 and `nota` = symbol[index].
    - On a transfer (valid && ready at the clock edge) of a non-final symbol: go to GAP with gap counter = GAP. If GAP = 0, go straight to SEND with index + 1.
    - On a transfer of the final symbol: go to IDLE and pulse `done`.
  - GAP: `nota_valid` = 0. Decrement the counter each cycle; when it reaches 1, go to SEND with index + 1.
- While `nota_valid` = 1 and `nota_ready` = 0, `nota` is held stable and `nota_valid` stays high. There is no timeout.
- When `nota_valid` = 0, `nota` = 0000.
- `busy` is 1 in SEND and GAP, and 0 in IDLE.
- `start` is ignored while `busy` = 1.

## Timing
- Reset values: all outputs 0 (`nota` = 0000, `nota_valid`, `busy`, `done`, `erro` all 0), state IDLE, index 0, gap counter 0.
- Reset mid-word aborts immediately. No `done` and no further symbols are produced.
- Start latency: `start` is sampled at edge N. `busy` and `nota_valid` go high after edge N, and symbol 0 is presented in cycle N+1. For a rejected start, `erro` is high in cycle N+1 only.
- Spacing: with `nota_ready` tied to 1, symbols are presented in one cycle every GAP+1 cycles.
  - 4-symbol word: the last transfer is at edge N+1+3(GAP+1).
  - 5-symbol word: the last transfer is at edge N+1+4(GAP+1).
- Completion: `done` is high for the one cycle immediately after the final transfer. In that same cycle `busy` = 0 and the state is IDLE.
- A `start` sampled during the `done` cycle is accepted, giving back-to-back words.
- `erro` and `done` are never high in the same cycle.

## Test plan
- tipo = 01, var = 0, raiz0 = 0011, raiz1 = 0101, ready = 1, GAP = 2:
  - `nota` sequence is 0011, 0101, 1110, 0000, each valid for 1 cycle, 3 cycles apart.
  - `done` is high at cycle N+11.
- tipo = 10, var = 1, raiz0 = 0001, raiz1 = 1010, GAP = 0, ready = 1:
  - Sequence 0001, 1010, 1111, 0010, 0000 appears on consecutive cycles N+1..N+5.
  - `done` is high at N+6.
- tipo = 11, var = 1, ready held low for 4 cycles on symbol 2:
  - `nota` = 1110 is held stable and valid across the stall.
  - The sequence completes as ..., 1110, 1111, 0000.
- Start with tipo = 00, then a start with raiz1 = 1000:
  - `erro` is a one-cycle pulse each time.
  - `busy` and `nota_valid` stay 0.
- Word in flight:
  - A second `start` with different inputs is ignored; the sequence is unchanged.
  - A `start` during the `done` cycle launches the next word at the following cycle.
- Reset asserted asynchronously while symbol 3 is valid:
  - All outputs are 0 immediately.
  - No `done` is produced.
  - The next start emits from symbol 0.

Source files
------------

// File: rtl/note_sequence_player.sv
// note_sequence_player: emits the 4- or 5-symbol note word for adjective/comparative/adverb on start.
// Latency: symbol 0 is presented the cycle after start is sampled; GAP idle cycles follow each accepted symbol.
// Backpressure: nota is held stable with nota_valid high until nota_ready; there is no timeout.
module note_sequence_player #(
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] tipo,
    input  logic       var_sel,    // branch select; `var` is a reserved word in SystemVerilog
    input  logic [3:0] raiz0,
    input  logic [3:0] raiz1,
    output logic [3:0] nota,
    output logic       nota_valid,
    input  logic       nota_ready,
    output logic       busy,
    output logic       done,
    output logic       erro
);

    localparam logic [3:0] PAUSE   = 4'b0000;
    localparam logic [3:0] NOTE_DO = 4'b0001;
    localparam logic [3:0] NOTE_RE = 4'b0010;
    localparam logic [3:0] LA_M    = 4'b1110;
    localparam logic [3:0] SI_M    = 4'b1111;

    localparam logic [1:0] T_NULL = 2'b00;
    localparam logic [1:0] T_ADJ  = 2'b01;
    localparam logic [1:0] T_COMP = 2'b10;
    localparam logic [1:0] T_ADV  = 2'b11;

    localparam logic [3:0] GAP_INIT = 4'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [3:0] gap_cnt, gap_cnt_nxt;
    logic       done_nxt, erro_nxt;

    // Word captured at an accepted start; later input changes do not affect the word in flight.
    logic [1:0] tipo_r;
    logic       var_r;
    logic [3:0] raiz0_r, raiz1_r;

    logic       start_ok;
    logic       last_sym;
    logic [3:0] sym;

    // A stem note may not be either pause code (0000 or 1000), so its low three bits must be non-zero.
    assign start_ok = (tipo != T_NULL) && (raiz0[2:0] != 3'b000) && (raiz1[2:0] != 3'b000);

    // Adjectives end after index 3; comparatives and adverbs after index 4.
    assign last_sym = (tipo_r == T_ADJ) ? (idx == 3'd3) : (idx == 3'd4);

    // Symbol table indexed by position within the word.
    always_comb begin
        sym = PAUSE;
        case (idx)
            3'd0: sym = raiz0_r;
            3'd1: sym = raiz1_r;
            3'd2: sym = ((tipo_r != T_ADV) && var_r) ? SI_M : LA_M;
            3'd3: begin
                case (tipo_r)
                    T_COMP:  sym = var_r ? NOTE_RE : NOTE_DO;
                    T_ADV:   sym = SI_M;
                    default: sym = PAUSE;
                endcase
            end
            default: sym = PAUSE;
        endcase
    end

    // Next-state logic: accept/reject start, advance on transfer, count out the inter-symbol gap.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        gap_cnt_nxt = gap_cnt;
        done_nxt    = 1'b0;
        erro_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_nxt = ST_SEND;
                        idx_nxt   = 3'd0;
                    end else begin
                        erro_nxt  = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (nota_ready) begin
                    if (last_sym) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = 3'd0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                        if (GAP == 0) begin
                            state_nxt = ST_SEND;
                        end else begin
                            state_nxt   = ST_GAP;
                            gap_cnt_nxt = GAP_INIT;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt <= 4'd1) begin
                    state_nxt   = ST_SEND;
                    gap_cnt_nxt = 4'd0;
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                idx_nxt     = 3'd0;
                gap_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State, index, gap counter and the one-cycle done/erro pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            gap_cnt <= 4'd0;
            done    <= 1'b0;
            erro    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_cnt_nxt;
            done    <= done_nxt;
            erro    <= erro_nxt;
        end
    end

    // Capture the word parameters only when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tipo_r  <= T_NULL;
            var_r   <= 1'b0;
            raiz0_r <= PAUSE;
            raiz1_r <= PAUSE;
        end else if ((state == ST_IDLE) && start && start_ok) begin
            tipo_r  <= tipo;
            var_r   <= var_sel;
            raiz0_r <= raiz0;
            raiz1_r <= raiz1;
        end
    end

    assign nota_valid = (state == ST_SEND);
    assign nota       = nota_valid ? sym : PAUSE;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_note_sequence_player.sv
// Self-checking bench for note_sequence_player: two instances (GAP=2 and GAP=0) share the stimulus,
// one selected at a time; every cycle the selected instance is compared with a transfer-schedule model.
// Directed steps cover the documented scenarios, then randomized words with random backpressure.
module tb_note_sequence_player;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic [1:0] tipo;
    logic       var_sel;
    logic [3:0] raiz0, raiz1;
    logic       nota_ready;
    logic       sel;

    logic       start_a, start_b;
    logic [3:0] nota_a, nota_b;
    logic       nota_valid_a, nota_valid_b;
    logic       busy_a, busy_b, done_a, done_b, erro_a, erro_b;

    logic [3:0] nota;
    logic       nota_valid, busy, done, erro;

    assign start_a    = start & ~sel;
    assign start_b    = start & sel;
    assign nota       = sel ? nota_b       : nota_a;
    assign nota_valid = sel ? nota_valid_b : nota_valid_a;
    assign busy       = sel ? busy_b       : busy_a;
    assign done       = sel ? done_b       : done_a;
    assign erro       = sel ? erro_b       : erro_a;

    note_sequence_player #(.GAP(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tipo(tipo), .var_sel(var_sel),
        .raiz0(raiz0), .raiz1(raiz1), .nota(nota_a), .nota_valid(nota_valid_a),
        .nota_ready(nota_ready), .busy(busy_a), .done(done_a), .erro(erro_a)
    );

    note_sequence_player #(.GAP(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tipo(tipo), .var_sel(var_sel),
        .raiz0(raiz0), .raiz1(raiz1), .nota(nota_b), .nota_valid(nota_valid_b),
        .nota_ready(nota_ready), .busy(busy_b), .done(done_b), .erro(erro_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: expected symbol list plus the cycle at which the next symbol should appear.
    int         cyc;
    int         gap_v;
    bit         in_word;
    int         k;
    int         len;
    int         pres_at;
    logic [3:0] seq [5];
    bit         done_exp, erro_exp;
    int         ready_mode;   // 0: always ready, 1: random, 2: stall symbol 2
    int         stall_left;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit legal_root(input logic [3:0] r);
        return (r != 4'b0000) && (r != 4'b1000);
    endfunction

    task automatic load_word();
        seq[0] = raiz0;
        seq[1] = raiz1;
        seq[4] = 4'h0;
        case (tipo)
            2'b01: begin len = 4; seq[2] = var_sel ? 4'hF : 4'hE; seq[3] = 4'h0; end
            2'b10: begin len = 5; seq[2] = var_sel ? 4'hF : 4'hE; seq[3] = var_sel ? 4'h2 : 4'h1; end
            default: begin len = 5; seq[2] = 4'hE; seq[3] = 4'hF; end
        endcase
    endtask

    task automatic check_outputs();
        bit         v;
        logic [3:0] n;
        v = in_word && (cyc >= pres_at);
        n = v ? seq[k] : 4'h0;
        chk("nota",       {4'h0, nota},       {4'h0, n});
        chk("nota_valid", {7'h0, nota_valid}, {7'h0, v});
        chk("busy",       {7'h0, busy},       {7'h0, in_word});
        chk("done",       {7'h0, done},       {7'h0, done_exp});
        chk("erro",       {7'h0, erro},       {7'h0, erro_exp});
    endtask

    // One clock: choose ready, advance the model across the coming edge, then compare after it.
    task automatic step();
        bit v;
        v = in_word && (cyc >= pres_at);
        case (ready_mode)
            0: nota_ready = 1'b1;
            1: nota_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (v && k == 2 && stall_left > 0) begin
                    nota_ready = 1'b0;
                    stall_left--;
                end else begin
                    nota_ready = 1'b1;
                end
            end
        endcase
        done_exp = 1'b0;
        erro_exp = 1'b0;
        if (v && nota_ready) begin
            k++;
            if (k == len) begin
                in_word  = 1'b0;
                done_exp = 1'b1;
            end else begin
                pres_at = cyc + 1 + gap_v;
            end
        end else if (!in_word && start) begin
            if (tipo == 2'b00 || !legal_root(raiz0) || !legal_root(raiz1)) begin
                erro_exp = 1'b1;
            end else begin
                load_word();
                in_word = 1'b1;
                k       = 0;
                pres_at = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    // Launch a word in the current cycle and step until the model reaches its done cycle.
    task automatic run_word(input logic [1:0] t, input logic v, input logic [3:0] r0,
                            input logic [3:0] r1, input bit chaos);
        tipo    = t;
        var_sel = v;
        raiz0   = r0;
        raiz1   = r1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int i = 0; i < 300 && in_word; i++) begin
            if (chaos) begin
                start   = ($urandom_range(0, 2) == 0);
                tipo    = 2'($urandom_range(0, 3));
                var_sel = 1'($urandom_range(0, 1));
                raiz0   = 4'($urandom_range(0, 15));
                raiz1   = 4'($urandom_range(0, 15));
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic select_dut(input logic s);
        sel   = s;
        gap_v = s ? 0 : 2;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        tipo       = 2'b00;
        var_sel    = 1'b0;
        raiz0      = 4'h0;
        raiz1      = 4'h0;
        nota_ready = 1'b0;
        sel        = 1'b0;
        gap_v      = 2;
        cyc        = 0;
        in_word    = 1'b0;
        k          = 0;
        len        = 0;
        pres_at    = 0;
        done_exp   = 1'b0;
        erro_exp   = 1'b0;
        ready_mode = 0;
        stall_left = 0;
        for (int i = 0; i < 5; i++) seq[i] = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;
        step();

        // Adjective la_m, GAP=2, always ready
        run_word(2'b01, 1'b0, 4'b0011, 4'b0101, 1'b0);
        step();
        step();

        // Comparative si_m, GAP=0, always ready
        select_dut(1'b1);
        run_word(2'b10, 1'b1, 4'b0001, 4'b1010, 1'b0);
        step();

        // Adverb with a 4-cycle stall on symbol 2
        select_dut(1'b0);
        ready_mode = 2;
        stall_left = 4;
        run_word(2'b11, 1'b1, 4'b0110, 4'b0111, 1'b0);
        ready_mode = 0;
        step();

        // Rejected starts: null type, then a pause code as second stem
        run_word(2'b00, 1'b0, 4'b0011, 4'b0101, 1'b0);
        step();
        run_word(2'b01, 1'b0, 4'b0011, 4'b1000, 1'b0);
        step();
        run_word(2'b10, 1'b0, 4'b0000, 4'b0101, 1'b0);
        step();

        // Inputs and start toggle during a word; then back-to-back words from the done cycle
        run_word(2'b01, 1'b1, 4'b1001, 4'b0100, 1'b1);
        run_word(2'b10, 1'b0, 4'b0111, 4'b1101, 1'b0);
        select_dut(1'b1);
        run_word(2'b11, 1'b0, 4'b0010, 4'b1100, 1'b1);
        run_word(2'b01, 1'b0, 4'b0101, 4'b0110, 1'b0);
        step();

        // Asynchronous reset while symbol 3 is presented
        select_dut(1'b0);
        tipo    = 2'b10;
        var_sel = 1'b0;
        raiz0   = 4'b0011;
        raiz1   = 4'b0100;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int i = 0; i < 100 && !(in_word && k == 3 && cyc >= pres_at); i++) step();
        chk("sym3_reached", {7'h0, nota_valid}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        in_word  = 1'b0;
        done_exp = 1'b0;
        erro_exp = 1'b0;
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        repeat (6) step();
        run_word(2'b01, 1'b1, 4'b1011, 4'b0001, 1'b0);
        step();

        // Randomized words with random backpressure on both gap settings
        ready_mode = 1;
        for (int w = 0; w < 40; w++) begin
            if (!in_word) select_dut(1'($urandom_range(0, 1)));
            run_word(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end
        ready_mode = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
